// File: rtl/pacote_borda.sv
// pacote_borda: shared edge-type encoding and arbiter FSM states
package pacote_borda;
   localparam logic [1:0] TIPO_NENHUM  = 2'b00;
   localparam logic [1:0] TIPO_SUBIDA  = 2'b01;
   localparam logic [1:0] TIPO_DESCIDA = 2'b10;
   localparam logic [1:0] TIPO_AMBAS   = 2'b11;
   typedef enum logic {OCIOSO, OFERTA} estado_t;
endpackage

// File: rtl/celula_borda.sv
// celula_borda: per-channel edge detector with pending flags and sticky overflow
module celula_borda (
   input  logic       clk,
   input  logic       rst,
   input  logic       entrada,
   input  logic [1:0] modo,
   input  logic       limpa_sub,
   input  logic       limpa_desc,
   input  logic       limpa_perdido,
   output logic       pend_sub,
   output logic       pend_desc,
   output logic       perdido
);
   logic entrada_q, sub, desc;
   always_comb begin
      sub  = entrada & ~entrada_q & modo[0];
      desc = ~entrada & entrada_q & modo[1];
   end
   // a new edge always wins over a same-cycle clear, of pending bits and of perdido
   always_ff @(posedge clk)
      if (rst) begin
         entrada_q <= entrada;
         pend_sub  <= 1'b0;
         pend_desc <= 1'b0;
         perdido   <= 1'b0;
      end else begin
         entrada_q <= entrada;
         pend_sub  <= sub | (pend_sub & ~limpa_sub);
         pend_desc <= desc | (pend_desc & ~limpa_desc);
         perdido   <= (sub & pend_sub & ~limpa_sub) | (desc & pend_desc & ~limpa_desc) | (perdido & ~limpa_perdido);
      end
endmodule

// File: rtl/arbitro_bordas.sv
// arbitro_bordas: round-robin server of per-channel edge events over valid/ready
module arbitro_bordas
   import pacote_borda::*;
#(
   parameter int N_CANAIS = 4,
   parameter int W_CANAL  = $clog2(N_CANAIS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CANAIS-1:0] entrada,
   input  logic [1:0]          modo,
   input  logic                evento_pronto,
   input  logic                limpa_perdido,
   output logic                evento_valido,
   output logic [W_CANAL-1:0]  evento_canal,
   output logic [1:0]          evento_tipo,
   output logic [N_CANAIS-1:0] perdido
);
   estado_t estado;
   logic [W_CANAL-1:0] ponteiro, escolha, idx;
   logic [N_CANAIS-1:0] pend_sub, pend_desc, limpa_sub, limpa_desc;
   logic algum, aceite;
   assign evento_valido = estado == OFERTA;
   assign aceite = evento_valido & evento_pronto;
   for (genvar i = 0; i < N_CANAIS; i++) begin : g_celula
      assign limpa_sub[i]  = aceite & (evento_canal == W_CANAL'(i)) & evento_tipo[0];
      assign limpa_desc[i] = aceite & (evento_canal == W_CANAL'(i)) & evento_tipo[1];
      celula_borda u_celula (
         .clk(clk),
         .rst(rst),
         .entrada(entrada[i]),
         .modo(modo),
         .limpa_sub(limpa_sub[i]),
         .limpa_desc(limpa_desc[i]),
         .limpa_perdido(limpa_perdido),
         .pend_sub(pend_sub[i]),
         .pend_desc(pend_desc[i]),
         .perdido(perdido[i])
      );
   end
   // scanning downward lets the channel closest above ponteiro overwrite the others
   always_comb begin
      escolha = '0;
      algum = 1'b0;
      idx = '0;
      for (int k = N_CANAIS - 1; k >= 0; k--) begin
         idx = W_CANAL'((int'(ponteiro) + k) % N_CANAIS);
         if (pend_sub[idx] | pend_desc[idx]) begin
            escolha = idx;
            algum = 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         estado       <= OCIOSO;
         ponteiro     <= '0;
         evento_canal <= '0;
         evento_tipo  <= TIPO_NENHUM;
      end else if (estado == OCIOSO) begin
         if (algum) begin
            estado       <= OFERTA;
            evento_canal <= escolha;
            evento_tipo  <= {pend_desc[escolha], pend_sub[escolha]};
         end
      end else if (evento_pronto) begin
         estado   <= OCIOSO;
         ponteiro <= evento_canal == W_CANAL'(N_CANAIS - 1) ? '0 : evento_canal + W_CANAL'(1);
      end
endmodule

// File: tb/tb_arbitro_bordas.sv
// tb_arbitro_bordas: directed scenarios plus randomized run against a cycle-level event model
module tb_arbitro_bordas;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst, evento_pronto, limpa_perdido, evento_valido;
   logic [N-1:0] entrada, perdido;
   logic [1:0] modo, evento_tipo, evento_canal;
   int checks = 0, passes = 0;
   logic [N-1:0] m_prev, m_sub, m_desc, m_perd;
   logic m_valid;
   logic [1:0] m_tipo;
   int m_canal, m_ptr;

   always #5 clk = ~clk;

   arbitro_bordas #(.N_CANAIS(N)) dut (
      .clk(clk),
      .rst(rst),
      .entrada(entrada),
      .modo(modo),
      .evento_pronto(evento_pronto),
      .limpa_perdido(limpa_perdido),
      .evento_valido(evento_valido),
      .evento_canal(evento_canal),
      .evento_tipo(evento_tipo),
      .perdido(perdido)
   );

   // what the outputs should be after one clock edge with the current inputs
   function automatic void modelo();
      logic [N-1:0] s0, d0;
      logic hs, sobe, desce, cs, cd;
      int c;
      s0 = m_sub;
      d0 = m_desc;
      hs = m_valid && evento_pronto;
      if (rst) begin
         m_prev = entrada; m_sub = '0; m_desc = '0; m_perd = '0;
         m_valid = 1'b0; m_tipo = 2'b00; m_canal = 0; m_ptr = 0;
         return;
      end
      for (int i = 0; i < N; i++) begin
         sobe  = entrada[i] && !m_prev[i] && modo[0];
         desce = !entrada[i] && m_prev[i] && modo[1];
         cs = hs && m_canal == i && m_tipo[0];
         cd = hs && m_canal == i && m_tipo[1];
         m_perd[i] = (sobe && s0[i] && !cs) || (desce && d0[i] && !cd) || (m_perd[i] && !limpa_perdido);
         m_sub[i]  = sobe || (s0[i] && !cs);
         m_desc[i] = desce || (d0[i] && !cd);
      end
      m_prev = entrada;
      if (hs) begin
         m_valid = 1'b0;
         m_ptr = (m_canal + 1) % N;
      end else if (!m_valid) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (s0[c] || d0[c]) begin
               m_valid = 1'b1;
               m_canal = c;
               m_tipo = {d0[c], s0[c]};
               break;
            end
         end
      end
   endfunction

   task automatic ciclo();
      @(posedge clk);
      modelo();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; entrada = 4'b1010; modo = 2'b11; evento_pronto = 1'b1; limpa_perdido = 1'b0;
      ciclo(); ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL reset_valid: got %b want 0", evento_valido); else passes++;
      checks++; if (evento_canal !== 2'd0) $display("FAIL reset_canal: got %0d want 0", evento_canal); else passes++;
      checks++; if (evento_tipo !== 2'b00) $display("FAIL reset_tipo: got %b want 00", evento_tipo); else passes++;
      checks++; if (perdido !== 4'b0000) $display("FAIL reset_perdido: got %b want 0000", perdido); else passes++;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ciclo();
         checks++; if ({evento_valido, perdido} !== 5'b0) $display("FAIL reset_quiet: cycle %0d valid=%b perdido=%b want 0/0000", i, evento_valido, perdido); else passes++;
      end
   endtask

   task automatic test_subida();
      modo = 2'b01; entrada = 4'b0000;
      ciclo(); ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL sub_masked_fall: got valid %b want 0", evento_valido); else passes++;
      entrada = 4'b0100;
      ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL sub_latency: got valid %b want 0", evento_valido); else passes++;
      ciclo();
      checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd2, 2'b01}) $display("FAIL sub_offer: got v=%b c=%0d t=%b want v=1 c=2 t=01", evento_valido, evento_canal, evento_tipo); else passes++;
      ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL sub_done: got valid %b want 0", evento_valido); else passes++;
      for (int i = 0; i < 5; i++) begin
         ciclo();
         checks++; if (evento_valido !== 1'b0) $display("FAIL sub_no_more: cycle %0d got valid %b want 0", i, evento_valido); else passes++;
      end
   endtask

   task automatic test_round_robin();
      int q[$];
      rst = 1'b1; entrada = 4'b0000; modo = 2'b11; evento_pronto = 1'b0;
      ciclo();
      rst = 1'b0; entrada = 4'b1011;
      ciclo(); ciclo();
      checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd0, 2'b01}) $display("FAIL rr_first: got v=%b c=%0d t=%b want v=1 c=0 t=01", evento_valido, evento_canal, evento_tipo); else passes++;
      q.push_back(int'(evento_canal));
      for (int i = 0; i < 5; i++) begin
         ciclo();
         checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd0, 2'b01}) $display("FAIL rr_stable: cycle %0d got v=%b c=%0d t=%b want v=1 c=0 t=01", i, evento_valido, evento_canal, evento_tipo); else passes++;
      end
      evento_pronto = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ciclo();
         if (evento_valido) q.push_back(int'(evento_canal));
      end
      checks++; if (q.size() != 3) $display("FAIL rr_count: got %0d grants want 3", q.size()); else passes++;
      if (q.size() == 3) begin
         checks++; if (q[1] != 1) $display("FAIL rr_second: got %0d want 1", q[1]); else passes++;
         checks++; if (q[2] != 3) $display("FAIL rr_third: got %0d want 3", q[2]); else passes++;
      end
   endtask

   task automatic test_ambas();
      rst = 1'b1; entrada = 4'b0010; modo = 2'b11; evento_pronto = 1'b0;
      ciclo();
      rst = 1'b0; entrada = 4'b0011;
      ciclo(); ciclo();
      checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd0, 2'b01}) $display("FAIL ambas_hold: got v=%b c=%0d t=%b want v=1 c=0 t=01", evento_valido, evento_canal, evento_tipo); else passes++;
      entrada = 4'b0001; ciclo();
      entrada = 4'b0011; ciclo();
      evento_pronto = 1'b1; ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL ambas_gap: got valid %b want 0", evento_valido); else passes++;
      ciclo();
      checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd1, 2'b11}) $display("FAIL ambas_offer: got v=%b c=%0d t=%b want v=1 c=1 t=11", evento_valido, evento_canal, evento_tipo); else passes++;
      ciclo(); ciclo();
      checks++; if (evento_valido !== 1'b0) $display("FAIL ambas_single: got valid %b want 0", evento_valido); else passes++;
   endtask

   task automatic test_perdido();
      rst = 1'b1; entrada = 4'b0000; modo = 2'b01; evento_pronto = 1'b0; limpa_perdido = 1'b0;
      ciclo();
      rst = 1'b0; entrada = 4'b0001;
      ciclo(); ciclo();
      entrada = 4'b0000; ciclo();
      checks++; if (perdido !== 4'b0000) $display("FAIL perd_none: got %b want 0000", perdido); else passes++;
      entrada = 4'b0001; ciclo();
      checks++; if (perdido !== 4'b0001) $display("FAIL perd_set: got %b want 0001", perdido); else passes++;
      checks++; if ({evento_valido, evento_canal} !== {1'b1, 2'd0}) $display("FAIL perd_offer_kept: got v=%b c=%0d want v=1 c=0", evento_valido, evento_canal); else passes++;
      limpa_perdido = 1'b1; ciclo();
      limpa_perdido = 1'b0;
      checks++; if (perdido !== 4'b0000) $display("FAIL perd_clear: got %b want 0000", perdido); else passes++;
      entrada = 4'b0000; ciclo();
      entrada = 4'b0001; evento_pronto = 1'b1; ciclo();
      checks++; if ({evento_valido, perdido} !== 5'b0) $display("FAIL setwins_hs: got v=%b perdido=%b want 0/0000", evento_valido, perdido); else passes++;
      ciclo();
      checks++; if ({evento_valido, evento_canal, evento_tipo} !== {1'b1, 2'd0, 2'b01}) $display("FAIL setwins_reoffer: got v=%b c=%0d t=%b want v=1 c=0 t=01", evento_valido, evento_canal, evento_tipo); else passes++;
      ciclo();
      checks++; if ({evento_valido, perdido} !== 5'b0) $display("FAIL setwins_after: got v=%b perdido=%b want 0/0000", evento_valido, perdido); else passes++;
   endtask

   task automatic test_reset_meio();
      rst = 1'b1; entrada = 4'b0000; modo = 2'b11; evento_pronto = 1'b0;
      ciclo();
      rst = 1'b0; entrada = 4'b0101;
      ciclo(); ciclo();
      entrada = 4'b0000; ciclo();
      entrada = 4'b0101; ciclo();
      checks++; if ({evento_valido, perdido} !== 5'b10101) $display("FAIL mid_before: got v=%b perdido=%b want 1/0101", evento_valido, perdido); else passes++;
      rst = 1'b1; ciclo();
      rst = 1'b0;
      checks++; if ({evento_valido, evento_canal, evento_tipo, perdido} !== 9'b0) $display("FAIL mid_reset: got v=%b c=%0d t=%b perdido=%b want all 0", evento_valido, evento_canal, evento_tipo, perdido); else passes++;
      for (int i = 0; i < 4; i++) begin
         ciclo();
         checks++; if (evento_valido !== 1'b0) $display("FAIL mid_no_pending: cycle %0d got valid %b want 0", i, evento_valido); else passes++;
      end
   endtask

   task automatic test_aleatorio();
      rst = 1'b1; limpa_perdido = 1'b0;
      ciclo();
      for (int i = 0; i < 800; i++) begin
         entrada = entrada ^ 4'($urandom & $urandom);
         modo = 2'($urandom);
         evento_pronto = $urandom_range(3) != 0;
         limpa_perdido = $urandom_range(15) == 0;
         rst = $urandom_range(99) == 0;
         ciclo();
         checks++; if (evento_valido !== m_valid) $display("FAIL rand_valid: cycle %0d got %b want %b", i, evento_valido, m_valid); else passes++;
         checks++; if (evento_canal !== 2'(m_canal)) $display("FAIL rand_canal: cycle %0d got %0d want %0d", i, evento_canal, m_canal); else passes++;
         checks++; if (evento_tipo !== m_tipo) $display("FAIL rand_tipo: cycle %0d got %b want %b", i, evento_tipo, m_tipo); else passes++;
         checks++; if (perdido !== m_perd) $display("FAIL rand_perdido: cycle %0d got %b want %b", i, perdido, m_perd); else passes++;
      end
      rst = 1'b0; limpa_perdido = 1'b0;
   endtask

   initial begin
      rst = 1'b1; entrada = '0; modo = 2'b00; evento_pronto = 1'b0; limpa_perdido = 1'b0;
      test_reset();
      test_subida();
      test_round_robin();
      test_ambas();
      test_perdido();
      test_reset_meio();
      test_aleatorio();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
